uart_datetime_set_parser: RTL and testbench

//  Receive-side counterpart of the date/time display path: parses a "set clock" command arriving as UART bytes.

---
 rtl/uart_dt_pkg.sv | 90 +++++++++
 rtl/dt_range_check.sv | 21 ++
 rtl/uart_datetime_set_parser.sv | 215 +++++++++++++++++++++
 tb/tb_uart_datetime_set_parser.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_dt_pkg.sv
// Shared definitions for the UART "set clock" command path.
// Holds the FSM state encoding and the ASCII characters the frame uses.
// Also holds the frame position map, the error codes and small helpers.
// Frame layout, by byte index after the command byte:
//   0..1 day, 2 '.', 3..4 month, 5 '.', 6..9 year, 10 ' ',
//   11..12 hour, 13 ':', 14..15 minute, 16 ':', 17..18 second, 19 '\n'
package uart_dt_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FRAME = 1'b1
   } state_e;

   typedef enum logic [2:0] {
      FLD_NONE,
      FLD_DAY,
      FLD_MONTH,
      FLD_YEAR,
      FLD_HOUR,
      FLD_MINUTE,
      FLD_SECOND
   } field_e;

   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_9     = 8'h39;
   localparam logic [7:0] ASCII_DOT   = 8'h2E;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   localparam logic [4:0] POS_DAY0  = 5'd0;
   localparam logic [4:0] POS_DAY1  = 5'd1;
   localparam logic [4:0] POS_DOT0  = 5'd2;
   localparam logic [4:0] POS_MON0  = 5'd3;
   localparam logic [4:0] POS_MON1  = 5'd4;
   localparam logic [4:0] POS_DOT1  = 5'd5;
   localparam logic [4:0] POS_YEAR0 = 5'd6;
   localparam logic [4:0] POS_YEAR1 = 5'd7;
   localparam logic [4:0] POS_YEAR2 = 5'd8;
   localparam logic [4:0] POS_YEAR3 = 5'd9;
   localparam logic [4:0] POS_SPACE = 5'd10;
   localparam logic [4:0] POS_HOUR0 = 5'd11;
   localparam logic [4:0] POS_HOUR1 = 5'd12;
   localparam logic [4:0] POS_COL0  = 5'd13;
   localparam logic [4:0] POS_MIN0  = 5'd14;
   localparam logic [4:0] POS_MIN1  = 5'd15;
   localparam logic [4:0] POS_COL1  = 5'd16;
   localparam logic [4:0] POS_SEC0  = 5'd17;
   localparam logic [4:0] POS_SEC1  = 5'd18;
   localparam logic [4:0] POS_EOL   = 5'd19;

   localparam logic [1:0] ERR_FORMAT  = 2'd1;
   localparam logic [1:0] ERR_RANGE   = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   // Which field a digit at this position belongs to (FLD_NONE = separator).
   function automatic field_e field_at(input logic [4:0] pos);
      field_e f;
      case (pos)
         POS_DAY0, POS_DAY1:                       f = FLD_DAY;
         POS_MON0, POS_MON1:                       f = FLD_MONTH;
         POS_YEAR0, POS_YEAR1, POS_YEAR2, POS_YEAR3: f = FLD_YEAR;
         POS_HOUR0, POS_HOUR1:                     f = FLD_HOUR;
         POS_MIN0, POS_MIN1:                       f = FLD_MINUTE;
         POS_SEC0, POS_SEC1:                       f = FLD_SECOND;
         default:                                  f = FLD_NONE;
      endcase
      return f;
   endfunction

   // Expected separator byte at a non-digit position. Out-of-frame positions
   // return NUL so that they can never match a received byte.
   function automatic logic [7:0] sep_at(input logic [4:0] pos);
      logic [7:0] c;
      case (pos)
         POS_DOT0, POS_DOT1: c = ASCII_DOT;
         POS_SPACE:          c = ASCII_SPACE;
         POS_COL0, POS_COL1: c = ASCII_COLON;
         POS_EOL:            c = ASCII_LF;
         default:            c = 8'h00;
      endcase
      return c;
   endfunction

   // acc*10 + digit as two shifts and two adds, with no multiplier.
   function automatic logic [13:0] acc_step(input logic [13:0] acc, input logic [3:0] digit);
      return (acc << 3) + (acc << 1) + {10'd0, digit};
   endfunction

endpackage

// File: rtl/dt_range_check.sv
// Combinational range check on a parsed date/time.
// The calendar set path can reuse this block. It does not check days-in-month.
// Any 4-digit year is legal, so the year is not an input.
//   day_i, month_i, hour_i, minute_i, second_i : full-width parsed values (0..99)
//   ok_o : 1 when day 1..31, month 1..12, hour<=23, minute<=59, second<=59
module dt_range_check (
   input  logic [6:0] day_i,
   input  logic [6:0] month_i,
   input  logic [6:0] hour_i,
   input  logic [6:0] minute_i,
   input  logic [6:0] second_i,
   output logic       ok_o
);

   assign ok_o = (day_i    >= 7'd1) && (day_i   <= 7'd31) &&
                 (month_i  >= 7'd1) && (month_i <= 7'd12) &&
                 (hour_i   <= 7'd23) &&
                 (minute_i <= 7'd59) &&
                 (second_i <= 7'd59);

endmodule

// File: rtl/uart_datetime_set_parser.sv
// Parses the UART command 's' + "DD.MM.YYYY HH:MM:SS" + '\n' into binary
// date/time fields. The fields are handed to the clock/calendar counters.
//   clk_i, rst_n_i     : clock, asynchronous active-low reset
//   rx_data_i/valid_i  : byte stream from uart_rx (one-cycle valid strobe)
//   set_valid_o        : one-cycle strobe, fields hold a newly accepted value
//   day_o..second_o    : last accepted date/time
//   err_valid_o        : one-cycle strobe, frame rejected
//   err_code_o         : 1=format, 2=range, 3=timeout (sticky)
//   busy_o             : frame in progress
//
// state    | meaning
// ST_IDLE  | waiting for CMD_CHAR, other bytes dropped silently
// ST_FRAME | checking bytes by position idx_q, inter-byte timer running
module uart_datetime_set_parser
   import uart_dt_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
   parameter logic [7:0]  CMD_CHAR       = 8'h73
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        set_valid_o,
   output logic [4:0]  day_o,
   output logic [3:0]  month_o,
   output logic [13:0] year_o,
   output logic [4:0]  hour_o,
   output logic [5:0]  minute_o,
   output logic [5:0]  second_o,
   output logic        err_valid_o,
   output logic [1:0]  err_code_o,
   output logic        busy_o
);

   // The timer is a down-counter loaded with TIMEOUT_CYCLES-1. The cycle
   // that finds it at zero without a byte is the TIMEOUT_CYCLES-th idle cycle.
   localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

   state_e            state_q, state_d;
   logic [4:0]        idx_q, idx_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [6:0]        day_acc_q, day_acc_d;
   logic [6:0]        mon_acc_q, mon_acc_d;
   logic [13:0]       year_acc_q, year_acc_d;
   logic [6:0]        hour_acc_q, hour_acc_d;
   logic [6:0]        min_acc_q, min_acc_d;
   logic [6:0]        sec_acc_q, sec_acc_d;
   logic              set_q, set_d;
   logic              err_q, err_d;
   logic [1:0]        code_q, code_d;
   logic [4:0]        day_q;
   logic [3:0]        month_q;
   logic [13:0]       year_q;
   logic [4:0]        hour_q;
   logic [5:0]        minute_q;
   logic [5:0]        second_q;

   logic              range_ok;
   logic              rx_is_digit;
   logic [3:0]        digit;
   field_e            fld;

   dt_range_check u_range (
      .day_i    (day_acc_q),
      .month_i  (mon_acc_q),
      .hour_i   (hour_acc_q),
      .minute_i (min_acc_q),
      .second_i (sec_acc_q),
      .ok_o     (range_ok)
   );

   assign rx_is_digit = (rx_data_i >= ASCII_0) && (rx_data_i <= ASCII_9);
   // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
   assign digit       = rx_data_i[3:0];
   assign fld         = field_at(idx_q);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         timer_q    <= '0;
         day_acc_q  <= '0;
         mon_acc_q  <= '0;
         year_acc_q <= '0;
         hour_acc_q <= '0;
         min_acc_q  <= '0;
         sec_acc_q  <= '0;
         set_q      <= 1'b0;
         err_q      <= 1'b0;
         code_q     <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         timer_q    <= timer_d;
         day_acc_q  <= day_acc_d;
         mon_acc_q  <= mon_acc_d;
         year_acc_q <= year_acc_d;
         hour_acc_q <= hour_acc_d;
         min_acc_q  <= min_acc_d;
         sec_acc_q  <= sec_acc_d;
         set_q      <= set_d;
         err_q      <= err_d;
         code_q     <= code_d;
      end
   end

   // The published fields change only when a frame is accepted.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         day_q    <= '0;
         month_q  <= '0;
         year_q   <= '0;
         hour_q   <= '0;
         minute_q <= '0;
         second_q <= '0;
      end else if (set_d) begin
         day_q    <= day_acc_q[4:0];
         month_q  <= mon_acc_q[3:0];
         year_q   <= year_acc_q;
         hour_q   <= hour_acc_q[4:0];
         minute_q <= min_acc_q[5:0];
         second_q <= sec_acc_q[5:0];
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      timer_d    = timer_q;
      day_acc_d  = day_acc_q;
      mon_acc_d  = mon_acc_q;
      year_acc_d = year_acc_q;
      hour_acc_d = hour_acc_q;
      min_acc_d  = min_acc_q;
      sec_acc_d  = sec_acc_q;
      set_d      = 1'b0;
      err_d      = 1'b0;
      code_d     = code_q;

      case (state_q)
         ST_IDLE: begin
            if (rx_valid_i && (rx_data_i == CMD_CHAR)) begin
               state_d    = ST_FRAME;
               idx_d      = '0;
               timer_d    = TMR_LOAD;
               day_acc_d  = '0;
               mon_acc_d  = '0;
               year_acc_d = '0;
               hour_acc_d = '0;
               min_acc_d  = '0;
               sec_acc_d  = '0;
            end
         end
         ST_FRAME: begin
            if (rx_valid_i) begin
               // A byte always beats a timer expiring in the same cycle.
               timer_d = TMR_LOAD;
               idx_d   = 5'(idx_q + 5'd1);
               if (fld != FLD_NONE) begin
                  if (!rx_is_digit) begin
                     state_d = ST_IDLE;
                     err_d   = 1'b1;
                     code_d  = ERR_FORMAT;
                  end else begin
                     case (fld)
                        FLD_DAY:    day_acc_d  = 7'(acc_step({7'd0, day_acc_q}, digit));
                        FLD_MONTH:  mon_acc_d  = 7'(acc_step({7'd0, mon_acc_q}, digit));
                        FLD_YEAR:   year_acc_d = acc_step(year_acc_q, digit);
                        FLD_HOUR:   hour_acc_d = 7'(acc_step({7'd0, hour_acc_q}, digit));
                        FLD_MINUTE: min_acc_d  = 7'(acc_step({7'd0, min_acc_q}, digit));
                        FLD_SECOND: sec_acc_d  = 7'(acc_step({7'd0, sec_acc_q}, digit));
                        default: ;
                     endcase
                  end
               end else if (rx_data_i != sep_at(idx_q)) begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
                  code_d  = ERR_FORMAT;
               end else if (idx_q == POS_EOL) begin
                  state_d = ST_IDLE;
                  if (range_ok) begin
                     set_d = 1'b1;
                  end else begin
                     err_d  = 1'b1;
                     code_d = ERR_RANGE;
                  end
               end
            end else if (timer_q == '0) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
               code_d  = ERR_TIMEOUT;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o      = (state_q == ST_FRAME);
      set_valid_o = set_q;
      err_valid_o = err_q;
      err_code_o  = code_q;
      day_o       = day_q;
      month_o     = month_q;
      year_o      = year_q;
      hour_o      = hour_q;
      minute_o    = minute_q;
      second_o    = second_q;
   end

endmodule

// File: tb/tb_uart_datetime_set_parser.sv
module tb_uart_datetime_set_parser;

   localparam int TMO = 50;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        set_valid_o, err_valid_o, busy_o;
   logic [4:0]  day_o;
   logic [3:0]  month_o;
   logic [13:0] year_o;
   logic [4:0]  hour_o;
   logic [5:0]  minute_o;
   logic [5:0]  second_o;
   logic [1:0]  err_code_o;

   typedef struct {
      bit is_set;
      int day, month, year, hour, minute, second;
      int code;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   last_day = 0, last_month = 0, last_year = 0;
   int   last_hour = 0, last_minute = 0, last_second = 0;

   uart_datetime_set_parser #(.TIMEOUT_CYCLES(TMO), .CMD_CHAR(8'h73)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .rx_data_i   (rx_data),
      .rx_valid_i  (rx_valid),
      .set_valid_o (set_valid_o),
      .day_o       (day_o),
      .month_o     (month_o),
      .year_o      (year_o),
      .hour_o      (hour_o),
      .minute_o    (minute_o),
      .second_o    (second_o),
      .err_valid_o (err_valid_o),
      .err_code_o  (err_code_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input int got, input int expv);
      n_checks++;
      if (got != expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, expv);
      end
   endtask

   task automatic exp_set(input int d, input int m, input int y, input int h, input int mi, input int s);
      exp_t e;
      e.is_set = 1'b1; e.day = d; e.month = m; e.year = y;
      e.hour = h; e.minute = mi; e.second = s; e.code = 0;
      exp_q.push_back(e);
   endtask

   task automatic exp_err(input int c);
      exp_t e;
      e.is_set = 1'b0; e.day = 0; e.month = 0; e.year = 0;
      e.hour = 0; e.minute = 0; e.second = 0; e.code = c;
      exp_q.push_back(e);
   endtask

   // Called 1 time unit after a rising edge; the byte is sampled on the next edge.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_str(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) begin
         send_byte(s[i]);
         idle(gap);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         last_day = 0; last_month = 0; last_year = 0;
         last_hour = 0; last_minute = 0; last_second = 0;
      end else if (set_valid_o || err_valid_o) begin
         exp_t e;
         check("single_strobe", int'(set_valid_o && err_valid_o), 0);
         check("busy_low_on_strobe", int'(busy_o), 0);
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 1, 0);
         end else begin
            e = exp_q.pop_front();
            if (e.is_set) begin
               check("set_strobe", int'(set_valid_o), 1);
               check("day", int'(day_o), e.day);
               check("month", int'(month_o), e.month);
               check("year", int'(year_o), e.year);
               check("hour", int'(hour_o), e.hour);
               check("minute", int'(minute_o), e.minute);
               check("second", int'(second_o), e.second);
               last_day = e.day; last_month = e.month; last_year = e.year;
               last_hour = e.hour; last_minute = e.minute; last_second = e.second;
            end else begin
               check("err_strobe", int'(err_valid_o), 1);
               check("err_code", int'(err_code_o), e.code);
               check("date_held", int'({day_o, month_o, year_o}),
                     (last_day << 18) | (last_month << 14) | last_year);
               check("time_held", int'({hour_o, minute_o, second_o}),
                     (last_hour << 12) | (last_minute << 6) | last_second);
            end
         end
      end
   end

   initial begin
      bit early;

      // Reset state
      idle(2);
      check("rst_strobes", int'({set_valid_o, err_valid_o}), 0);
      check("rst_code", int'(err_code_o), 0);
      check("rst_busy", int'(busy_o), 0);
      check("rst_fields", int'({day_o, month_o, year_o, hour_o}) | int'({minute_o, second_o}), 0);
      rst_n = 1'b1;
      idle(2);

      // Good frame, checking busy along the way
      exp_set(30, 7, 2024, 21, 47, 54);
      send_byte("s");
      check("busy_after_cmd", int'(busy_o), 1);
      send_str("30.07.2024 21:47:54\n", 0);
      check("busy_drop_on_set", int'(busy_o), 0);
      check("set_now", int'(set_valid_o), 1);

      // Back-to-back frame at the upper boundaries
      exp_set(31, 12, 9999, 23, 59, 59);
      send_str("s31.12.9999 23:59:59\n", 0);
      idle(2);

      // Leading noise, lower boundaries
      exp_set(1, 1, 0, 0, 0, 0);
      send_str("xyzs01.01.0000 00:00:00\n", 2);
      idle(2);

      // Format error on '-', tail ignored, then good frame
      exp_err(1);
      send_str("s30-", 0);
      check("busy_after_fmt_err", int'(busy_o), 0);
      check("err_now", int'(err_valid_o), 1);
      send_str("07", 1);
      exp_set(15, 6, 2023, 12, 34, 56);
      send_str("s15.06.2023 12:34:56\n", 1);
      idle(2);

      // CMD_CHAR mid-frame is a format error and does not restart a frame
      exp_err(1);
      send_str("s1s01.01.2000 00:00:00\n", 0);
      idle(3);
      check("no_restart_busy", int'(busy_o), 0);

      // Range errors
      exp_err(2);
      send_str("s32.13.2024 25:60:60\n", 0);
      idle(2);
      exp_err(2);
      send_str("s00.05.2020 10:10:10\n", 0);
      idle(2);
      exp_err(2);
      send_str("s31.12.2020 24:00:00\n", 0);
      idle(2);
      exp_err(2);
      send_str("s10.00.2020 10:10:10\n", 0);
      idle(2);

      // Timeout exactly TMO idle cycles after the last byte
      exp_err(3);
      send_str("s30.0", 0);
      early = 1'b0;
      for (int k = 1; k < TMO; k++) begin
         @(posedge clk); #1;
         if (err_valid_o || !busy_o) early = 1'b1;
      end
      check("no_early_timeout", int'(early), 0);
      @(posedge clk); #1;
      check("timeout_strobe", int'(err_valid_o), 1);
      check("timeout_code", int'(err_code_o), 3);
      check("timeout_busy", int'(busy_o), 0);
      idle(2);

      // Byte landing on the expiry cycle wins
      exp_set(30, 7, 2024, 21, 47, 54);
      send_str("s30.0", 0);
      idle(TMO - 1);
      send_str("7.2024 21:47:54\n", 0);
      idle(2);

      // Reset mid-frame
      send_str("s30.07.", 0);
      rst_n = 1'b0;
      #2;
      check("midrst_busy", int'(busy_o), 0);
      check("midrst_code", int'(err_code_o), 0);
      check("midrst_fields", int'({day_o, month_o, year_o, hour_o}) | int'({minute_o, second_o}), 0);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      exp_set(9, 11, 1989, 8, 5, 3);
      send_str("s09.11.1989 08:05:03\n", 0);

      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
      idle(2);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
